// File: rtl/morse_pkg.sv
// Shared symbol codes, signal codes and player state encoding for the Morse player.
package morse_pkg;
  localparam logic [1:0] SYM_DOT     = 2'b00;
  localparam logic [1:0] SYM_DASH    = 2'b01;
  localparam logic [1:0] SYM_ILLEGAL = 2'b10;
  localparam logic [1:0] SYM_EMPTY   = 2'b11;
  localparam logic [9:0] SEQ_EMPTY   = 10'h3FF;

  localparam logic [2:0] DOT    = 3'b000;
  localparam logic [2:0] DASH   = 3'b001;
  localparam logic [2:0] SPACE  = 3'b010;
  localparam logic [2:0] ENDSEQ = 3'b011;

  localparam int         UNIT_W    = 8;
  localparam logic [2:0] MAX_SLOTS = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MARK  = 3'd2,
    GAP   = 3'd3,
    TRAIL = 3'd4
  } state_t;

  function automatic logic is_mark(input logic [1:0] sym);
    return (sym == SYM_DOT) || (sym == SYM_DASH);
  endfunction
endpackage

// File: rtl/morse_unit_timer.sv
// Unit timer: cycle prescaler plus unit down-counter; o_done marks the last cycle of the interval.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [UNIT_W-1:0] i_units,
  output logic              o_done
);
  localparam int            CW       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0]     r_cyc;
  logic [UNIT_W-1:0] r_left;
  logic              w_tick;

  assign w_tick = (r_cyc == CYC_LAST);
  assign o_done = w_tick && (r_left == UNIT_W'(1));

  // Prescaler wraps every unit; unit counter reloads on every state entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cyc  <= '0;
      r_left <= '0;
    end else if (i_start) begin
      r_cyc  <= '0;
      r_left <= i_units;
    end else if (r_left != '0) begin
      if (w_tick) begin
        r_cyc  <= '0;
        r_left <= r_left - UNIT_W'(1);
      end else begin
        r_cyc  <= r_cyc + CW'(1);
      end
    end
  end
endmodule

// File: rtl/morse_sequence_player.sv
// Plays a packed 10-bit Morse sequence as timed key on/off with registered outputs.
// Optional sidetone generator enabled by defining SIDETONE_EN.
module morse_sequence_player
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES      = 5_000_000,
  parameter int DASH_UNITS       = 3,
  parameter int LETTER_GAP_UNITS = 3,
  parameter int WORD_GAP_UNITS   = 7
`ifdef SIDETONE_EN
  ,
  parameter int TONE_DIV         = 50_000
`endif
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic [9:0] i_enc_seq,
  input  logic       i_space_endseqbar,
  input  logic       i_seq_valid,
  output logic       o_seq_ready,
  output logic       o_key,
  output logic       o_busy,
  output logic       o_msg_done,
  output logic       o_error,
  output logic       o_tone
);
  state_t            r_state, w_state_next;
  logic [9:0]        r_seq;
  logic              r_flag;
  logic [2:0]        r_idx;
  logic              r_key, r_ready, r_busy, r_msg_done, r_error;
  logic              w_clr, w_accept, w_done, w_start, w_last;
  logic [2:0]        w_idx_next;
  logic [UNIT_W-1:0] w_units;
  logic              w_key_next, w_ready_next, w_msg_next, w_err_next;

  assign w_clr      = i_reset | i_clear;
  assign w_accept   = (r_state == IDLE) && i_seq_valid;
  assign w_idx_next = (r_idx == MAX_SLOTS) ? r_idx : r_idx + 3'd1;
  // The current mark always sits in [9:8]; [7:6] is the slot that follows it.
  assign w_last     = (w_idx_next == MAX_SLOTS) || !is_mark(r_seq[7:6]);

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .i_clk   (i_clk),
    .i_reset (w_clr),
    .i_start (w_start),
    .i_units (w_units),
    .o_done  (w_done)
  );

  // State register and latched sequence datapath.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state <= IDLE;
      r_seq   <= SEQ_EMPTY;
      r_flag  <= 1'b0;
      r_idx   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_seq  <= i_enc_seq;
        r_flag <= i_space_endseqbar;
        r_idx  <= 3'd0;
      end else if ((r_state == MARK) && w_done) begin
        r_seq  <= {r_seq[7:0], SYM_EMPTY};
        r_idx  <= w_idx_next;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (w_clr) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = i_seq_valid ? LOAD : IDLE;
        LOAD:    w_state_next = is_mark(r_seq[9:8]) ? MARK : TRAIL;
        MARK:    w_state_next = w_done ? (w_last ? TRAIL : GAP) : MARK;
        GAP:     w_state_next = w_done ? MARK : GAP;
        TRAIL:   w_state_next = w_done ? IDLE : TRAIL;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Output and timer-load decode for the state being entered.
  always_comb begin
    w_start = (w_state_next != r_state) && !w_clr;
    w_units = '0;
    case (w_state_next)
      MARK:    w_units = (r_seq[9:8] == SYM_DASH) ? UNIT_W'(DASH_UNITS) : UNIT_W'(1);
      GAP:     w_units = UNIT_W'(1);
      TRAIL:   w_units = r_flag ? UNIT_W'(LETTER_GAP_UNITS) : UNIT_W'(WORD_GAP_UNITS);
      default: w_units = '0;
    endcase
    w_key_next   = (w_state_next == MARK);
    w_ready_next = (w_state_next == IDLE);
    w_msg_next   = !w_clr && (r_state == TRAIL) && w_done && !r_flag;
    w_err_next   = !w_clr &&
                   (((r_state == LOAD) && (r_seq[9:8] == SYM_ILLEGAL)) ||
                    ((r_state == MARK) && w_done && (w_idx_next != MAX_SLOTS) &&
                     (r_seq[7:6] == SYM_ILLEGAL)));
  end

  // Registered outputs.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_key      <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_msg_done <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_key      <= w_key_next;
      r_ready    <= w_ready_next;
      r_busy     <= !w_ready_next;
      r_msg_done <= w_msg_next;
      r_error    <= w_err_next;
    end
  end

  assign o_key       = r_key;
  assign o_seq_ready = r_ready;
  assign o_busy      = r_busy;
  assign o_msg_done  = r_msg_done;
  assign o_error     = r_error;

`ifdef SIDETONE_EN
  localparam int          TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  logic [TW-1:0] r_tone_div;
  logic          r_tone;

  // Sidetone follows the next key value so the tone never outlives the mark.
  always_ff @(posedge i_clk) begin
    if (w_clr || !w_key_next) begin
      r_tone_div <= '0;
      r_tone     <= 1'b0;
    end else if (r_tone_div == TW'(TONE_DIV - 1)) begin
      r_tone_div <= '0;
      r_tone     <= !r_tone;
    end else begin
      r_tone_div <= r_tone_div + TW'(1);
    end
  end

  assign o_tone = r_tone;
`else
  assign o_tone = 1'b0;
`endif
endmodule
